arm_pipe_ctrl: RTL

//  Parametrised pipeline controller for the ARM core: generalises hazard detection to MEM_STAGES memory stages.

---
 rtl/arm_pipe_pkg.sv | 29 ++
 rtl/arm_sb_match.sv | 55 +++++
 rtl/arm_pipe_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline controller.
//   SB_AW         register address width carried in scoreboard entries
//   FWD_RF        forwarding select value meaning "read the register file"
//   sb_entry_t    one in-flight instruction record {valid, wb_en, mem_r, mem_w, dest}
//   stall_state_e memory stall FSM states
//   mem_stages_ok legal range check for the MEM_STAGES parameter
package arm_pipe_pkg;

  localparam int unsigned SB_AW  = 4;
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r;
    logic             mem_w;
    logic [SB_AW-1:0] dest;
  } sb_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } stall_state_e;

  function automatic bit mem_stages_ok(input int unsigned n);
    return (n >= 1) && (n <= 3);
  endfunction

endpackage

// File: rtl/arm_sb_match.sv
// Combinational priority matcher of one source register against the scoreboard.
//   en_i        source is actually read by the ID instruction
//   src_i       source register address
//   sb_i        scoreboard, index 0 = EXE (youngest) ... D-1 = WB (oldest)
//   hit_o       match anywhere in EXE..last MEM stage (WB excluded)
//   load_hit_o  match on the EXE entry and that entry is a load
//   sel_o       i+1 of the youngest matching entry, skipping a matching load in EXE
module arm_sb_match
  import arm_pipe_pkg::*;
#(
  parameter int unsigned D          = 3,
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned FW         = 2
) (
  input  logic                    en_i,
  input  logic [SB_AW-1:0]        src_i,
  input  sb_entry_t [D-1:0]       sb_i,
  output logic                    hit_o,
  output logic                    load_hit_o,
  output logic [FW-1:0]           sel_o
);

  logic unused_mem;

  // Walk from youngest to oldest so the first match found wins the select.
  always_comb begin
    logic m;
    logic found;
    hit_o      = 1'b0;
    load_hit_o = 1'b0;
    sel_o      = FW'(FWD_RF);
    found      = 1'b0;
    m          = 1'b0;
    for (int i = 0; i < int'(D); i++) begin
      m = en_i & sb_i[i].valid & sb_i[i].wb_en & (sb_i[i].dest == src_i);
      if (m && (i <= int'(MEM_STAGES))) hit_o = 1'b1;
      // A load still in EXE has no data yet: flag it and look further back.
      if (m && (i == 0) && sb_i[i].mem_r) begin
        load_hit_o = 1'b1;
      end else if (m && !found) begin
        found = 1'b1;
        sel_o = FW'(i + 1);
      end
    end
  end

  // Memory-type flags of most entries do not affect matching.
  always_comb begin
    unused_mem = 1'b0;
    for (int i = 0; i < int'(D); i++) begin
      unused_mem = unused_mem ^ sb_i[i].mem_r ^ sb_i[i].mem_w;
    end
  end

endmodule

// File: rtl/arm_pipe_ctrl.sv
// Pipeline controller for the ARM core: hazard detection over MEM_STAGES memory
// stages, multi-cycle memory stall handshake, branch flush sequencing, optional
// operand forwarding selects and a saturating stall counter.
// Optional feature macro: FORWARDING_EN (load-use hazards only + fwd_sel outputs).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_*                          decoded ID-stage instruction
//   ex_br_taken                   branch resolved taken in EXE
//   mem_ready                     memory access completes in last MEM stage
//   freeze_pc, freeze_if_id       hold PC / IF-ID (combinational)
//   flush_if_id, flush_id_ex      clear IF-ID / bubble into ID-EX (combinational)
//   stall_back                    hold ID-EX and later stages (combinational)
//   hazard                        data hazard this cycle (combinational)
//   fwd_sel1, fwd_sel2            operand sources, 0 = RF, i+1 = scoreboard i
//   mem_timeout                   sticky memory wait timeout (registered)
//   stall_cnt                     saturating count of freeze cycles (registered)
module arm_pipe_ctrl
  import arm_pipe_pkg::*;
#(
  parameter  int unsigned REG_AW     = SB_AW,
  parameter  int unsigned MEM_STAGES = 1,
  parameter  int unsigned MAX_WAIT   = 15,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned D          = MEM_STAGES + 2,
  localparam int unsigned FW         = $clog2(D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_mem_r,
  input  logic              id_mem_w,
  input  logic              ex_br_taken,
  input  logic              mem_ready,
  output logic              freeze_pc,
  output logic              freeze_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              stall_back,
  output logic              hazard,
  output logic [FW-1:0]     fwd_sel1,
  output logic [FW-1:0]     fwd_sel2,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  if (!mem_stages_ok(MEM_STAGES) || (REG_AW != SB_AW)) begin : g_bad_cfg
    $error("arm_pipe_ctrl: unsupported MEM_STAGES or REG_AW");
  end

  sb_entry_t [D-1:0] sb_q, sb_d;
  sb_entry_t         id_ent;
  sb_entry_t         sb0_in;
  stall_state_e      state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_stall;
  logic              haz_raw;
  logic              src2_used;
  logic              hit1, hit2, lhit1, lhit2;
  logic [FW-1:0]     sel1, sel2;
  logic [FW-1:0]     fwd1_raw, fwd2_raw;

  assign id_ent = '{valid: id_valid, wb_en: id_wb_en, mem_r: id_mem_r,
                    mem_w: id_mem_w, dest: SB_AW'(id_dest)};

  // Access in the last MEM stage that memory has not yet completed.
  assign mem_stall = sb_q[MEM_STAGES].valid &
                     (sb_q[MEM_STAGES].mem_r | sb_q[MEM_STAGES].mem_w) & ~mem_ready;

  // A store reads its data register through src2 even without two_src.
  assign src2_used = id_valid & (id_two_src | id_mem_w);

  arm_sb_match #(.D(D), .MEM_STAGES(MEM_STAGES), .FW(FW)) u_match1 (
    .en_i       (id_valid),
    .src_i      (SB_AW'(id_src1)),
    .sb_i       (sb_q),
    .hit_o      (hit1),
    .load_hit_o (lhit1),
    .sel_o      (sel1)
  );

  arm_sb_match #(.D(D), .MEM_STAGES(MEM_STAGES), .FW(FW)) u_match2 (
    .en_i       (src2_used),
    .src_i      (SB_AW'(id_src2)),
    .sb_i       (sb_q),
    .hit_o      (hit2),
    .load_hit_o (lhit2),
    .sel_o      (sel2)
  );

`ifdef FORWARDING_EN
  // Everything but a load still in EXE can be forwarded.
  logic unused_hit;
  assign haz_raw    = lhit1 | lhit2;
  assign fwd1_raw   = sel1;
  assign fwd2_raw   = sel2;
  assign unused_hit = hit1 | hit2;
`else
  // No bypass network: wait until the producer reaches WB.
  logic unused_fwd;
  assign haz_raw    = hit1 | hit2;
  assign fwd1_raw   = FW'(FWD_RF);
  assign fwd2_raw   = FW'(FWD_RF);
  assign unused_fwd = ^{lhit1, lhit2, sel1, sel2};
`endif

  // Stage control: memory stall dominates, then branch flush, then data hazard.
  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    stall_back   = 1'b0;
    hazard       = 1'b0;
    fwd_sel1     = FW'(FWD_RF);
    fwd_sel2     = FW'(FWD_RF);
    if (!rst) begin
      fwd_sel1 = fwd1_raw;
      fwd_sel2 = fwd2_raw;
      if (mem_stall) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        stall_back   = 1'b1;
      end else if (ex_br_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (haz_raw) begin
        hazard       = 1'b1;
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_ex  = 1'b1;
      end
    end
  end

  // Scoreboard shift, stall FSM, wait timer and stall counter next state.
  always_comb begin
    sb_d      = sb_q;
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    sb0_in    = (id_valid && !haz_raw && !ex_br_taken) ? id_ent : '0;
    if (mem_stall) begin
      state_d = ST_WAIT;
      if (state_q == ST_RUN) begin
        wait_d = WW'(1);
      end else if (wait_q < WW'(MAX_WAIT)) begin
        wait_d = wait_q + WW'(1);
      end
      if (wait_d >= WW'(MAX_WAIT)) timeout_d = 1'b1;
    end else begin
      state_d = ST_RUN;
      wait_d  = '0;
      sb_d[0] = sb0_in;
      for (int i = 1; i < int'(D); i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end
    if ((freeze_pc || stall_back) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q      <= '0;
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sb_q      <= sb_d;
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = cnt_q;

endmodule
